ysyx_25040129_lsu: RTL and testbench
====================================

YSYX_25040129_LSU -- requirements
Module: ysyx_25040129_lsu

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high); clock clk.
REQ-002 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_mem_read in 3 load code; in_mem_write in 2 store code; in_addr in 32; in_wdata in 32; in_alu_result in 32; in_rd in 5; in_reg_write in 1.
REQ-003 SHALL have memory-side ports: req_valid out 1; req_ready in 1; rsp_valid in 1; rsp_ready out 1; mem_read out 3; mem_write out 2; mem_addr out 32; mem_write_data out 32; mem_read_data in 32, already sign- or zero-extended by main memory.
REQ-004 SHALL have downstream ports: out_valid out 1; out_ready in 1; out_data out 32; out_rd out 5; out_reg_write out 1; out_misalign out 1 (access trapped, no memory op issued).

Function
REQ-005 Load codes SHALL be NO=0, BYTE=1, HALF=2, WORD=3, BYTE_U=4, HALF_U=5; store codes SHALL be NO=0, BYTE=1, HALF=2, WORD=3; other values SHALL be treated as NO.
REQ-006 SHALL use FSM states IDLE, REQ, WAIT, DONE.
REQ-007 in_ready SHALL be 1 only in IDLE; transfer occurs when in_valid && in_ready, and all in_* fields SHALL be registered on that edge.
REQ-008 On IDLE transfer with load and store both NO, SHALL go to DONE with out_data = in_alu_result.
REQ-009 A load code != NO SHALL take priority over a store code; the other field SHALL be forwarded as NO.
REQ-010 Misalignment: HALF/HALF_U with addr[0]!=0, WORD with addr[1:0]!=0; SHALL go to DONE with out_misalign=1, out_reg_write=0, no request issued.
REQ-011 Otherwise SHALL go to REQ; req_valid=1 in REQ; mem_* outputs SHALL hold registered values stable while req_valid=1.
REQ-012 REQ -> WAIT on req_ready=1; otherwise SHALL remain in REQ.
REQ-013 rsp_ready SHALL be 1 only in WAIT; WAIT -> DONE on rsp_valid=1, latching mem_read_data into out_data for loads; stores SHALL keep out_data=0 and force out_reg_write=0.
REQ-014 out_valid SHALL be 1 only in DONE; DONE -> IDLE on out_ready=1; out_* SHALL hold stable while out_valid=1 && !out_ready.
REQ-015 Latency, all ready inputs held 1: non-memory op SHALL give out_valid 1 cycle after accept; memory op SHALL give req_valid 1 cycle after accept and out_valid 1 cycle after the rsp_valid cycle.
REQ-016 A new transaction SHALL be accepted no earlier than the cycle after the DONE handshake (one outstanding access).
REQ-017 Outside REQ, mem_read and mem_write SHALL drive NO; mem_addr and mem_write_data may hold their last value.
REQ-018 Store data SHALL pass unmasked; byte/half truncation is the memory's responsibility.

Reset
REQ-019 On rst SHALL enter IDLE: req_valid=0, rsp_ready=0, out_valid=0, in_ready=1, out_misalign=0, out_reg_write=0, out_data=0, out_rd=0, mem_read=NO, mem_write=NO.
REQ-020 rst asserted mid-transaction SHALL abandon the access with no response tracking; memory is reset by the same rst.

Structure
REQ-021 Load/store code constants and FSM state encodings SHALL live in the shared core package/defines file also used by the main memory and EXU.
REQ-022 Alignment check SHALL be a combinational sub-module ysyx_25040129_lsu_align (inputs code, addr[1:0]; output misalign); everything else flat.

Verification
REQ-023 Non-memory op: alu_result=0x1234, rd=5, reg_write=1, out_ready=1 -> out_valid next cycle, out_data=0x1234, out_rd=5, no req_valid.
REQ-024 LW addr=0x80000004, memory returns 0xDEADBEEF -> mem_read=WORD for one req handshake, out_data=0xDEADBEEF, out_reg_write=1.
REQ-025 SH addr=0x80000003 -> out_misalign=1 after 1 cycle, req_valid never 1, out_reg_write=0.
REQ-026 SB addr=0x80000010 wdata=0xAB, req_ready low 3 cycles -> req_valid and mem_* stable all 4 cycles, mem_write=BYTE, out_reg_write=0.
REQ-027 LB completes with out_ready low 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; in_ready=1 the cycle after handshake.
REQ-028 rst pulsed while in WAIT -> next cycle IDLE, in_ready=1, all valids 0, subsequent LW completes normally.

Source files
------------

// File: rtl/ysyx_25040129_lsu_pkg.sv
// rtl/ysyx_25040129_lsu_pkg.sv - load/store codes and LSU FSM states shared with memory and EXU
package ysyx_25040129_lsu_pkg;

  localparam logic [2:0] LD_NO     = 3'd0;
  localparam logic [2:0] LD_BYTE   = 3'd1;
  localparam logic [2:0] LD_HALF   = 3'd2;
  localparam logic [2:0] LD_WORD   = 3'd3;
  localparam logic [2:0] LD_BYTE_U = 3'd4;
  localparam logic [2:0] LD_HALF_U = 3'd5;

  localparam logic [1:0] ST_NO   = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_HALF = 2'd2;
  localparam logic [1:0] ST_WORD = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Undefined load encodings collapse to NO so they behave like a plain ALU op.
  function automatic logic [2:0] norm_load(input logic [2:0] code);
    return (code > LD_HALF_U) ? LD_NO : code;
  endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// rtl/ysyx_25040129_lsu_align.sv - combinational alignment check for an access code
module ysyx_25040129_lsu_align
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic [2:0] code,
  input  logic [1:0] addr,
  output logic       misalign
);

  // Store codes share the numbering of BYTE/HALF/WORD loads, so one decoder serves both.
  always_comb begin
    misalign = 1'b0;
    case (code)
      LD_HALF, LD_HALF_U: misalign = addr[0];
      LD_WORD:            misalign = |addr;
      default:            misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// rtl/ysyx_25040129_lsu.sv - single-outstanding load/store unit between EXU, memory and WBU
module ysyx_25040129_lsu
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_mem_read,
  input  logic [1:0]  in_mem_write,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_alu_result,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        req_valid,
  input  logic        req_ready,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  output logic [2:0]  mem_read,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_misalign
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  ld_code, eff_code, ld_q;
  logic [1:0]  st_code, st_q;
  logic        is_mem, in_misalign, accept;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [4:0]  rd_q;
  logic        rw_q, mis_q;

  // A real load wins; the store field is then dropped to NO.
  assign ld_code  = norm_load(in_mem_read);
  assign st_code  = (ld_code != LD_NO) ? ST_NO : in_mem_write;
  assign eff_code = (ld_code != LD_NO) ? ld_code : {1'b0, st_code};
  assign is_mem   = (eff_code != LD_NO);
  assign accept   = in_valid && in_ready;

  ysyx_25040129_lsu_align u_align (
    .code     (eff_code),
    .addr     (in_addr[1:0]),
    .misalign (in_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = (!is_mem || in_misalign) ? LSU_DONE : LSU_REQ;
      LSU_REQ:  if (req_ready) state_d = LSU_WAIT;
      LSU_WAIT: if (rsp_valid) state_d = LSU_DONE;
      LSU_DONE: if (out_ready) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LSU_IDLE);
    req_valid = (state_q == LSU_REQ);
    rsp_ready = (state_q == LSU_WAIT);
    out_valid = (state_q == LSU_DONE);
    mem_read  = (state_q == LSU_REQ) ? ld_q : LD_NO;
    mem_write = (state_q == LSU_REQ) ? st_q : ST_NO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q    <= LD_NO;
      st_q    <= ST_NO;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      ld_q    <= ld_code;
      st_q    <= st_code;
      addr_q  <= in_addr;
      wdata_q <= in_wdata;
      rd_q    <= in_rd;
      mis_q   <= is_mem && in_misalign;
      data_q  <= is_mem ? 32'd0 : in_alu_result;
      // Stores and trapped accesses never write back.
      rw_q    <= in_reg_write && (!is_mem || (ld_code != LD_NO && !in_misalign));
    end else if (state_q == LSU_WAIT && rsp_valid && ld_q != LD_NO) begin
      data_q  <= mem_read_data;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign out_data       = data_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = rw_q;
  assign out_misalign   = mis_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// tb/tb_ysyx_25040129_lsu.sv - scoreboard bench for the LSU with a behavioural memory and sink
module tb_ysyx_25040129_lsu;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [2:0] in_mem_read;
  logic [1:0] in_mem_write;
  logic [31:0] in_addr, in_wdata, in_alu_result;
  logic [4:0] in_rd;
  logic in_reg_write;
  logic req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0] mem_read;
  logic [1:0] mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0] out_rd;
  logic out_reg_write, out_misalign;

  always #5 clk = ~clk;

  ysyx_25040129_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_result(in_alu_result), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .req_valid(req_valid), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_misalign(out_misalign)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chk_data;
  } exp_t;

  typedef struct {
    logic [2:0]  rcode;
    logic [1:0]  wcode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];
  int checks = 0;
  int failures = 0;

  int req_hold = 0, out_hold = 0;
  bit req_rand = 0, rsp_rand = 0, out_rand = 0, rsp_hold = 0;
  bit pending = 0;
  logic [31:0] pend_addr;
  int req_hs_count = 0, out_hs_count = 0, req_stall_cnt = 0, out_stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event", name);
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_9617;
  endfunction

  // Memory model: accepts requests, checks them against the scoreboard, answers later.
  logic prev_req_stall = 1'b0;
  logic [2:0] p_rd; logic [1:0] p_wr; logic [31:0] p_addr, p_wdata;
  initial begin
    req_t r;
    req_ready = 1'b0; rsp_valid = 1'b0; mem_read_data = 32'd0;
    forever begin
      @(negedge clk);
      if (prev_req_stall) begin
        check("req_hold_valid", 32'(req_valid), 32'd1);
        check("req_hold_read", 32'(mem_read), 32'(p_rd));
        check("req_hold_write", 32'(mem_write), 32'(p_wr));
        check("req_hold_addr", mem_addr, p_addr);
        check("req_hold_wdata", mem_write_data, p_wdata);
      end
      if (!req_valid) check("mem_codes_no_outside_req", {27'd0, mem_read, mem_write}, 32'd0);
      if (req_hold > 0 && req_valid) begin
        req_ready = 1'b0;
        req_hold--;
      end else begin
        req_ready = req_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (req_valid && req_ready) begin
        req_hs_count++;
        if (req_q.size() == 0) fail_now("unexpected_req");
        else begin
          r = req_q.pop_front();
          check("req_mem_read", 32'(mem_read), 32'(r.rcode));
          check("req_mem_write", 32'(mem_write), 32'(r.wcode));
          check("req_addr", mem_addr, r.addr);
          check("req_wdata", mem_write_data, r.wdata);
        end
        pending = 1'b1;
        pend_addr = mem_addr;
      end
      prev_req_stall = req_valid && !req_ready;
      if (prev_req_stall) req_stall_cnt++;
      p_rd = mem_read; p_wr = mem_write; p_addr = mem_addr; p_wdata = mem_write_data;
      if (pending && rsp_ready && !rsp_hold && (!rsp_rand || $urandom_range(0, 2) == 0)) begin
        rsp_valid = 1'b1;
        mem_read_data = mem_val(pend_addr);
        pending = 1'b0;
      end else begin
        rsp_valid = 1'b0;
        mem_read_data = $urandom();
      end
    end
  end

  // Downstream sink and scoreboard monitor.
  logic prev_out_stall = 1'b0;
  logic [31:0] o_data; logic [4:0] o_rd; logic o_rw, o_mis;
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_out_stall) begin
        check("out_hold_valid", 32'(out_valid), 32'd1);
        check("out_hold_data", out_data, o_data);
        check("out_hold_rd", 32'(out_rd), 32'(o_rd));
        check("out_hold_rw", 32'(out_reg_write), 32'(o_rw));
        check("out_hold_mis", 32'(out_misalign), 32'(o_mis));
      end
      if (out_valid) check("in_ready_low_in_done", 32'(in_ready), 32'd0);
      if (out_hold > 0 && out_valid) begin
        out_ready = 1'b0;
        out_hold--;
      end else begin
        out_ready = out_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (out_valid && out_ready) begin
        out_hs_count++;
        if (exp_q.size() == 0) fail_now("unexpected_out");
        else begin
          e = exp_q.pop_front();
          if (e.chk_data) check("out_data", out_data, e.data);
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("out_reg_write", 32'(out_reg_write), 32'(e.rw));
          check("out_misalign", 32'(out_misalign), 32'(e.mis));
        end
      end
      prev_out_stall = out_valid && !out_ready;
      if (prev_out_stall) out_stall_cnt++;
      o_data = out_data; o_rd = out_rd; o_rw = out_reg_write; o_mis = out_misalign;
    end
  end

  // Reference model: derive access size from the codes, then the expected outcome.
  task automatic send(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd,
                      input logic rw);
    exp_t e; req_t r;
    int size, n;
    bit is_load, is_store, mis;
    logic [2:0] ld_eff;
    ld_eff = (ld >= 3'd1 && ld <= 3'd5) ? ld : 3'd0;
    is_load = (ld_eff != 0);
    is_store = !is_load && (st != 0);
    size = 1;
    if (is_load) size = (ld_eff == 1 || ld_eff == 4) ? 1 : (ld_eff == 2 || ld_eff == 5) ? 2 : 4;
    else if (is_store) size = (st == 1) ? 1 : (st == 2) ? 2 : 4;
    mis = (is_load || is_store) && ((addr % size) != 0);
    e.rd = rd;
    if (!is_load && !is_store) begin e.data = alu; e.rw = rw; e.mis = 0; e.chk_data = 1; end
    else if (mis) begin e.data = 0; e.rw = 0; e.mis = 1; e.chk_data = 0; end
    else if (is_load) begin e.data = mem_val(addr); e.rw = rw; e.mis = 0; e.chk_data = 1; end
    else begin e.data = 0; e.rw = 0; e.mis = 0; e.chk_data = 1; end
    r.rcode = is_load ? ld_eff : 3'd0;
    r.wcode = is_store ? st : 2'd0;
    r.addr = addr;
    r.wdata = wdata;

    @(negedge clk);
    in_valid = 1'b1; in_mem_read = ld; in_mem_write = st; in_addr = addr;
    in_wdata = wdata; in_alu_result = alu; in_rd = rd; in_reg_write = rw;
    n = 0;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      if ((is_load || is_store) && !mis) req_q.push_back(r);
      @(negedge clk);
      in_valid = 1'b0;
      in_mem_read = 3'($urandom()); in_mem_write = 2'($urandom()); in_addr = $urandom();
      in_wdata = $urandom(); in_alu_result = $urandom(); in_rd = 5'($urandom());
      in_reg_write = 1'($urandom());
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || !in_ready) fail_now("drain_timeout");
  endtask

  initial begin
    #2_000_000;
    fail_now("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    rst = 1'b1; in_valid = 1'b0; in_mem_read = 0; in_mem_write = 0; in_addr = 0;
    in_wdata = 0; in_alu_result = 0; in_rd = 0; in_reg_write = 0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_valids", {29'd0, req_valid, rsp_ready, out_valid}, 32'd0);
    check("rst_out_flags", {30'd0, out_misalign, out_reg_write}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    check("rst_mem_codes", {27'd0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;

    send(3'd0, 2'd0, 32'h8000_0000, 32'h0, 32'h1234, 5'd5, 1'b1);
    check("alu_latency_out_valid", 32'(out_valid), 32'd1);
    check("alu_no_req", 32'(req_valid), 32'd0);
    drain();

    base = req_hs_count;
    send(3'd3, 2'd0, 32'h8000_0004, 32'h0, 32'h0, 5'd7, 1'b1);
    check("lw_req_latency", 32'(req_valid), 32'd1);
    drain();
    check("lw_one_req", 32'(req_hs_count - base), 32'd1);

    send(3'd0, 2'd2, 32'h8000_0003, 32'h5555, 32'h0, 5'd3, 1'b1);
    check("sh_mis_latency", 32'(out_valid), 32'd1);
    check("sh_mis_no_req", 32'(req_valid), 32'd0);
    drain();

    base = req_stall_cnt;
    req_hold = 3;
    send(3'd0, 2'd1, 32'h8000_0010, 32'h0000_00AB, 32'h0, 5'd9, 1'b1);
    drain();
    check("sb_req_stall_cycles", 32'(req_stall_cnt - base), 32'd3);

    base = out_stall_cnt;
    n = out_hs_count;
    out_hold = 5;
    send(3'd1, 2'd0, 32'h8000_0021, 32'h0, 32'h0, 5'd12, 1'b1);
    while (out_hs_count == n && out_stall_cnt - base < 40) @(negedge clk);
    check("lb_out_stall_cycles", 32'(out_stall_cnt - base), 32'd5);
    @(negedge clk);
    check("lb_in_ready_after_hs", 32'(in_ready), 32'd1);
    drain();

    rsp_hold = 1'b1;
    send(3'd3, 2'd0, 32'h8000_0040, 32'h0, 32'h0, 5'd1, 1'b1);
    n = 0;
    while (!rsp_ready && n < 50) begin @(negedge clk); n++; end
    if (!rsp_ready) fail_now("reach_wait_timeout");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_valids", {29'd0, req_valid, rsp_ready, out_valid}, 32'd0);
    rst = 1'b0;
    exp_q.delete(); req_q.delete();
    pending = 1'b0; rsp_hold = 1'b0;
    send(3'd3, 2'd0, 32'h8000_0048, 32'h0, 32'h0, 5'd2, 1'b1);
    drain();

    req_rand = 1'b1; rsp_rand = 1'b1; out_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [2:0] ld; logic [1:0] st;
      ld = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(0, 7));
      st = 2'($urandom_range(0, 3));
      send(ld, st, 32'h8000_0000 | ($urandom() & 32'h0000_FFFF), $urandom(), $urandom(),
           5'($urandom()), 1'($urandom()));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
